lsu_byte_lane_aligner: RTL and testbench
========================================

Name: lsu_byte_lane_aligner

Overview:
Parametrised successor to the fixed 32/64-bit byte maskers: a sequential load/store lane aligner between the CPU memory stage and the data bus. Takes one access (address, size 2^n bytes, load/store) and generates byte enables shifted to the address offset. Aligns store data onto lanes and returns load data right-justified and zero/sign-extended. Accesses that cross a bus-word boundary are split into two bus beats by an internal FSM.

Parameters:
DATA_W, 64, bus/register data width in bits; power of two, >= 16
ADDR_W, 64, address width
NB (derived), DATA_W/8, bytes per bus word; OFS_W = log2(NB); SIZE_W = 2 for the default DATA_W

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  access request
req_ready  out  1  aligner can accept request
req_addr  in  ADDR_W  byte address
req_size  in  SIZE_W  log2(access bytes); values > OFS_W treated as OFS_W
req_we  in  1  1 = store, 0 = load
req_signed  in  1  sign-extend load result
req_wdata  in  DATA_W  store data, right-justified
bus_valid  out  1  beat request
bus_ready  in  1  beat accepted; bus_rdata valid in same cycle
bus_addr  out  ADDR_W  word-aligned address (low OFS_W bits zero)
bus_we  out  1  store beat
bus_be  out  NB  byte enables
bus_wdata  out  DATA_W  lane-aligned store data
bus_rdata  in  DATA_W  read data
rsp_valid  out  1  access complete
rsp_ready  in  1  consumer takes response
rsp_rdata  out  DATA_W  load result, right-justified, extended (0 for stores)
rsp_err  out  1  misalignment trap (optional feature only; else 0)

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; bus_valid=0, bus_be=0, bus_we=0, bus_addr=0, bus_wdata=0; rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset mid-access abandons it; no beat re-issued after release.
- Definitions: bytes B = 1<<size; ofs = addr[OFS_W-1:0]; m = (1<<B)-1 (NB bits); split = (ofs + B > NB).
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid: register request, go BEAT0 next cycle. req_ready=0 in all other states.
- BEAT0: bus_valid=1, bus_addr = addr with low bits cleared, bus_be = (m << ofs) truncated to NB, bus_wdata = wdata << 8*ofs. On bus_ready: capture rdata; go BEAT1 if split, else RESP.
- BEAT1: bus_addr = BEAT0 address + NB (wraps modulo 2^ADDR_W), bus_be = m >> (NB-ofs), bus_wdata = wdata >> 8*(NB-ofs). On bus_ready go RESP.
- Bus outputs held stable while bus_valid=1 and bus_ready=0.
- Load assembly: low part = beat0 rdata >> 8*ofs; if split, OR in beat1 rdata << 8*(NB-ofs). Mask to B bytes. If req_signed and B<NB, replicate bit 8B-1; else zero-fill.
- RESP: rsp_valid=1 with rsp_rdata stable until rsp_ready; then IDLE. rsp_ready is ignored outside RESP.
- Latency (bus_ready tied 1, rsp_ready tied 1): aligned access = 3 cycles from request acceptance to rsp_valid deassert; split access = 4 cycles. No back-to-back overlap: the next req is accepted in the cycle after the RESP handshake.
- Full-width aligned (B=NB, ofs=0): bus_be all ones; never split.

Optional Feature:
MISALIGN_TRAP_EN. If defined: a request with split=1 issues no bus beat. IDLE goes directly to RESP with rsp_err=1 and rsp_rdata=0. BEAT1 is unreachable. If undefined: split accesses take two beats, and rsp_err is tied to 0.

Test Plan:
- Aligned 8-byte load, addr 0x1000, bus_rdata 0x1122334455667788 -> one beat: bus_addr 0x1000, bus_be 0xFF; rsp_rdata 0x1122334455667788.
- Signed byte load, addr 0x1003, rdata 0x00000000_80000000 -> bus_be 0x08; rsp_rdata 0xFFFFFFFFFFFFFF80. Repeat with req_signed=0 -> 0x80.
- Halfword store, addr 0x2006, wdata 0xBEEF -> bus_be 0xC0, bus_wdata 0xBEEF000000000000, bus_we 1; rsp_rdata 0.
- Split word load, addr 0x3006. Beat0 rdata 0xDDCC000000000000, beat1 rdata 0x000000000000BBAA -> beats at 0x3000 (be 0xC0) and 0x3008 (be 0x03); rsp_rdata 0xBBAADDCC.
- Backpressure: bus_ready low 3 cycles during BEAT0 -> bus outputs stable. Then hold rsp_ready low 2 cycles -> rsp_valid and rsp_rdata held, req_ready 0. Assert rst mid-BEAT1 -> all outputs reset immediately.
- With MISALIGN_TRAP_EN: 4-byte load at 0x3006 -> no bus_valid; rsp_valid with rsp_err=1 and rsp_rdata 0, one cycle after acceptance.

Source files
------------

// File: rtl/lsu_byte_lane_aligner.sv
// rtl/lsu_byte_lane_aligner.sv - load/store byte lane aligner, splits word-crossing accesses into two beats; MISALIGN_TRAP_EN traps them instead
module lsu_byte_lane_aligner #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64,
   parameter int NB     = DATA_W / 8,
   parameter int OFS_W  = $clog2(NB),
   parameter int SIZE_W = $clog2(OFS_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [SIZE_W-1:0] req_size,
   input  logic              req_we,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [NB-1:0]     bus_be,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   localparam int                BW       = OFS_W + 1;
   localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(OFS_W);
   localparam logic [31:0]       NB_U     = 32'(NB);

   state_t              state;
   logic [OFS_W-1:0]    ofs_r;
   logic [SIZE_W-1:0]   size_r;
   logic                sgn_r;
   logic [DATA_W-1:0]   wdata_r;
   logic [DATA_W-1:0]   rdata0_r;

   // access length in bytes; oversize requests collapse to a full bus word
   function automatic logic [BW-1:0] nbytes(input logic [SIZE_W-1:0] s);
      logic [SIZE_W-1:0] e;
      e = (s > MAX_SIZE) ? MAX_SIZE : s;
      return BW'(1) << e;
   endfunction

   function automatic logic is_split(input logic [OFS_W-1:0] ofs, input logic [SIZE_W-1:0] s);
      return (32'(ofs) + 32'(nbytes(s))) > NB_U;
   endfunction

   // low half = beat0 enables, high half = beat1 enables
   function automatic logic [2*NB-1:0] be_pair(input logic [OFS_W-1:0] ofs, input logic [SIZE_W-1:0] s);
      logic [2*NB-1:0] m;
      m = ((2*NB)'(1) << nbytes(s)) - (2*NB)'(1);
      return m << ofs;
   endfunction

   // low half = beat0 lanes, high half = beat1 lanes
   function automatic logic [2*DATA_W-1:0] wd_pair(input logic [OFS_W-1:0] ofs, input logic [DATA_W-1:0] wd);
      return {{DATA_W{1'b0}}, wd} << {ofs, 3'b000};
   endfunction

   // right-justify the two beats, trim to the access size and extend
   function automatic logic [DATA_W-1:0] load_result(input logic [OFS_W-1:0] ofs, input logic [SIZE_W-1:0] s,
                                                    input logic sgn, input logic [DATA_W-1:0] lo,
                                                    input logic [DATA_W-1:0] hi);
      logic [DATA_W-1:0] raw;
      logic [DATA_W-1:0] keep;
      logic [BW-1:0]     nb;
      logic              fill;
      nb  = nbytes(s);
      raw = DATA_W'({hi, lo} >> {ofs, 3'b000});
      if (nb == BW'(NB))
         keep = '1;
      else
         keep = (DATA_W'(1) << {nb, 3'b000}) - DATA_W'(1);
      fill = sgn && (nb != BW'(NB)) && (|(raw & (DATA_W'(1) << ({nb, 3'b000} - (BW+3)'(1)))));
      return (raw & keep) | (fill ? ~keep : '0);
   endfunction

   assign req_ready = (state == IDLE);

`ifndef MISALIGN_TRAP_EN
   assign rsp_err = 1'b0;
`endif

   // access sequencer: request capture, one or two bus beats, response hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ofs_r     <= '0;
         size_r    <= '0;
         sgn_r     <= 1'b0;
         wdata_r   <= '0;
         rdata0_r  <= '0;
         bus_valid <= 1'b0;
         bus_addr  <= '0;
         bus_we    <= 1'b0;
         bus_be    <= '0;
         bus_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
         rsp_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  ofs_r   <= req_addr[OFS_W-1:0];
                  size_r  <= req_size;
                  sgn_r   <= req_signed;
                  wdata_r <= req_wdata;
`ifdef MISALIGN_TRAP_EN
                  if (is_split(req_addr[OFS_W-1:0], req_size)) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else
`endif
                  begin
                     state     <= BEAT0;
                     bus_valid <= 1'b1;
                     bus_we    <= req_we;
                     bus_addr  <= {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                     bus_be    <= NB'(be_pair(req_addr[OFS_W-1:0], req_size));
                     bus_wdata <= DATA_W'(wd_pair(req_addr[OFS_W-1:0], req_wdata));
                  end
               end
            end
            BEAT0: begin
               if (bus_ready) begin
                  if (is_split(ofs_r, size_r)) begin
                     state     <= BEAT1;
                     rdata0_r  <= bus_rdata;
                     bus_addr  <= bus_addr + ADDR_W'(NB);
                     bus_be    <= NB'(be_pair(ofs_r, size_r) >> NB);
                     bus_wdata <= DATA_W'(wd_pair(ofs_r, wdata_r) >> DATA_W);
                  end else begin
                     state     <= RESP;
                     bus_valid <= 1'b0;
                     bus_be    <= '0;
                     bus_we    <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= bus_we ? '0 : load_result(ofs_r, size_r, sgn_r, bus_rdata, '0);
                  end
               end
            end
            BEAT1: begin
               if (bus_ready) begin
                  state     <= RESP;
                  bus_valid <= 1'b0;
                  bus_be    <= '0;
                  bus_we    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= bus_we ? '0 : load_result(ofs_r, size_r, sgn_r, rdata0_r, bus_rdata);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
`ifdef MISALIGN_TRAP_EN
                  rsp_err   <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_lane_aligner.sv
// tb/tb_lsu_byte_lane_aligner.sv - directed vector bench for lsu_byte_lane_aligner
module tb_lsu_byte_lane_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_signed;
   logic [63:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        bus_valid, bus_ready, bus_we;
   logic [63:0] bus_addr, bus_wdata, bus_rdata;
   logic [7:0]  bus_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [63:0] rsp_rdata;

   int total = 0;
   int bad   = 0;

   lsu_byte_lane_aligner #(.DATA_W(64), .ADDR_W(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_size(req_size),
      .req_we(req_we), .req_signed(req_signed), .req_wdata(req_wdata),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [1:0]  size;
      logic        we;
      logic        sgn;
      logic [63:0] wdata;
      logic [63:0] rd0;
      logic [63:0] rd1;
      logic        split;
      logic [63:0] a0;
      logic [63:0] a1;
      logic [7:0]  be0;
      logic [7:0]  be1;
      logic [63:0] wd0;
      logic [63:0] wd1;
      logic [63:0] rsp;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_beat(input string tag, input logic [63:0] a, input logic [7:0] be,
                             input logic we, input logic [63:0] wd);
      chk({tag, "_valid"}, {63'd0, bus_valid}, 64'd1);
      chk({tag, "_addr"}, bus_addr, a);
      chk({tag, "_be"}, {56'd0, bus_be}, {56'd0, be});
      chk({tag, "_we"}, {63'd0, bus_we}, {63'd0, we});
      chk({tag, "_wdata"}, bus_wdata, wd);
   endtask

   // called just after a falling edge; returns just after a falling edge
   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      chk({t, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      req_valid  = 1'b1;
      req_addr   = v.addr;
      req_size   = v.size;
      req_we     = v.we;
      req_signed = v.sgn;
      req_wdata  = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (v.split) begin
         chk({t, "_trap_no_beat"}, {63'd0, bus_valid}, 64'd0);
         chk({t, "_trap_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
         chk({t, "_trap_err"}, {63'd0, rsp_err}, 64'd1);
         chk({t, "_trap_rdata"}, rsp_rdata, 64'd0);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         chk({t, "_trap_idle"}, {63'd0, req_ready}, 64'd1);
         return;
      end
`endif
      check_beat({t, "_b0"}, v.a0, v.be0, v.we, v.wd0);
      bus_rdata = v.rd0;
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      if (v.split) begin
         check_beat({t, "_b1"}, v.a1, v.be1, v.we, v.wd1);
         bus_rdata = v.rd1;
         bus_ready = 1'b1;
         @(negedge clk);
         bus_ready = 1'b0;
      end
      bus_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
      chk({t, "_bus_idle"}, {63'd0, bus_valid}, 64'd0);
      chk({t, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({t, "_rsp_rdata"}, rsp_rdata, v.rsp);
      chk({t, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
      chk({t, "_busy"}, {63'd0, req_ready}, 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({t, "_done"}, {63'd0, rsp_valid}, 64'd0);
      chk({t, "_ready_again"}, {63'd0, req_ready}, 64'd1);
   endtask

   task automatic check_reset_state(input string t);
      chk({t, "_req_ready"}, {63'd0, req_ready}, 64'd1);
      chk({t, "_bus_valid"}, {63'd0, bus_valid}, 64'd0);
      chk({t, "_bus_be"}, {56'd0, bus_be}, 64'd0);
      chk({t, "_bus_we"}, {63'd0, bus_we}, 64'd0);
      chk({t, "_bus_addr"}, bus_addr, 64'd0);
      chk({t, "_bus_wdata"}, bus_wdata, 64'd0);
      chk({t, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
      chk({t, "_rsp_rdata"}, rsp_rdata, 64'd0);
      chk({t, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
   endtask

   initial begin
      vt[0]  = '{addr:64'h1000, size:2'd3, we:1'b0, sgn:1'b0, wdata:64'h0, rd0:64'h1122334455667788, rd1:64'h0, split:1'b0, a0:64'h1000, a1:64'h0, be0:8'hFF, be1:8'h00, wd0:64'h0, wd1:64'h0, rsp:64'h1122334455667788};
      vt[1]  = '{addr:64'h1003, size:2'd0, we:1'b0, sgn:1'b1, wdata:64'h0, rd0:64'h0000000080000000, rd1:64'h0, split:1'b0, a0:64'h1000, a1:64'h0, be0:8'h08, be1:8'h00, wd0:64'h0, wd1:64'h0, rsp:64'hFFFFFFFFFFFFFF80};
      vt[2]  = '{addr:64'h1003, size:2'd0, we:1'b0, sgn:1'b0, wdata:64'h0, rd0:64'h0000000080000000, rd1:64'h0, split:1'b0, a0:64'h1000, a1:64'h0, be0:8'h08, be1:8'h00, wd0:64'h0, wd1:64'h0, rsp:64'h80};
      vt[3]  = '{addr:64'h2006, size:2'd1, we:1'b1, sgn:1'b0, wdata:64'hBEEF, rd0:64'hFFFFFFFFFFFFFFFF, rd1:64'h0, split:1'b0, a0:64'h2000, a1:64'h0, be0:8'hC0, be1:8'h00, wd0:64'hBEEF000000000000, wd1:64'h0, rsp:64'h0};
      vt[4]  = '{addr:64'h3006, size:2'd2, we:1'b0, sgn:1'b0, wdata:64'h0, rd0:64'hDDCC000000000000, rd1:64'h000000000000BBAA, split:1'b1, a0:64'h3000, a1:64'h3008, be0:8'hC0, be1:8'h03, wd0:64'h0, wd1:64'h0, rsp:64'hBBAADDCC};
      vt[5]  = '{addr:64'h0100, size:2'd1, we:1'b0, sgn:1'b1, wdata:64'h0, rd0:64'h000000000000FFFE, rd1:64'h0, split:1'b0, a0:64'h0100, a1:64'h0, be0:8'h03, be1:8'h00, wd0:64'h0, wd1:64'h0, rsp:64'hFFFFFFFFFFFFFFFE};
      vt[6]  = '{addr:64'h4004, size:2'd3, we:1'b1, sgn:1'b0, wdata:64'h0123456789ABCDEF, rd0:64'h0, rd1:64'h0, split:1'b1, a0:64'h4000, a1:64'h4008, be0:8'hF0, be1:8'h0F, wd0:64'h89ABCDEF00000000, wd1:64'h0000000001234567, rsp:64'h0};
      vt[7]  = '{addr:64'hFFFFFFFFFFFFFFFF, size:2'd1, we:1'b0, sgn:1'b1, wdata:64'h0, rd0:64'h8800000000000000, rd1:64'h00000000000000F1, split:1'b1, a0:64'hFFFFFFFFFFFFFFF8, a1:64'h0, be0:8'h80, be1:8'h01, wd0:64'h0, wd1:64'h0, rsp:64'hFFFFFFFFFFFFF188};
      vt[8]  = '{addr:64'h2004, size:2'd2, we:1'b0, sgn:1'b1, wdata:64'h0, rd0:64'h7FFFFFFF00000000, rd1:64'h0, split:1'b0, a0:64'h2000, a1:64'h0, be0:8'hF0, be1:8'h00, wd0:64'h0, wd1:64'h0, rsp:64'h7FFFFFFF};
      vt[9]  = '{addr:64'h0008, size:2'd3, we:1'b0, sgn:1'b1, wdata:64'h0, rd0:64'h8000000000000001, rd1:64'h0, split:1'b0, a0:64'h0008, a1:64'h0, be0:8'hFF, be1:8'h00, wd0:64'h0, wd1:64'h0, rsp:64'h8000000000000001};
      vt[10] = '{addr:64'h0005, size:2'd0, we:1'b1, sgn:1'b0, wdata:64'hA5, rd0:64'h0, rd1:64'h0, split:1'b0, a0:64'h0000, a1:64'h0, be0:8'h20, be1:8'h00, wd0:64'h0000A50000000000, wd1:64'h0, rsp:64'h0};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_size   = '0;
      req_we     = 1'b0;
      req_signed = 1'b0;
      req_wdata  = '0;
      bus_ready  = 1'b0;
      bus_rdata  = '0;
      rsp_ready  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         run_vec(vt[i], i);

      // bus and response backpressure on a signed byte load
      req_valid  = 1'b1;
      req_addr   = 64'h1003;
      req_size   = 2'd0;
      req_we     = 1'b0;
      req_signed = 1'b1;
      req_wdata  = 64'h0;
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_beat($sformatf("bp_stall%0d", c), 64'h1000, 8'h08, 1'b0, 64'h0);
         bus_rdata = 64'hDEAD0000BEEF0000 + 64'(c);
         @(negedge clk);
      end
      check_beat("bp_release", 64'h1000, 8'h08, 1'b0, 64'h0);
      bus_rdata = 64'h0000000080000000;
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("bp_rsp_valid%0d", c), {63'd0, rsp_valid}, 64'd1);
         chk($sformatf("bp_rsp_rdata%0d", c), rsp_rdata, 64'hFFFFFFFFFFFFFF80);
         chk($sformatf("bp_req_ready%0d", c), {63'd0, req_ready}, 64'd0);
         @(negedge clk);
      end
      chk("bp_rsp_final", rsp_rdata, 64'hFFFFFFFFFFFFFF80);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_rsp_drop", {63'd0, rsp_valid}, 64'd0);

`ifndef MISALIGN_TRAP_EN
      // asynchronous reset while the second beat is pending
      req_valid = 1'b1;
      req_addr  = 64'h3006;
      req_size  = 2'd2;
      @(negedge clk);
      req_valid = 1'b0;
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      check_beat("mid_b1", 64'h3008, 8'h03, 1'b0, 64'h0);
      #2 rst = 1'b1;
      #1 check_reset_state("async_rst");
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst_bus%0d", c), {63'd0, bus_valid}, 64'd0);
         chk($sformatf("post_rst_rsp%0d", c), {63'd0, rsp_valid}, 64'd0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
